// File: rtl/seq_detect_pkg.sv
// Shared types and elaboration-time helpers for the Moore serial sequence detector.
// Optional match counter is enabled by defining SEQDET_MATCH_COUNT_EN.
package seq_detect_pkg;

  localparam int          DEF_PAT_LEN = 4;
  localparam logic [15:0] DEF_PATTERN = 16'h000B;
  localparam int          DEF_STATE_W = $clog2(DEF_PAT_LEN + 1);
  localparam int          CNT_W       = 8;

  typedef logic [DEF_STATE_W-1:0] state_idx_t;

  // Longest pattern prefix that is a suffix of (prefix_state, b); the pattern MSB is received first.
  function automatic int calc_next_state(input logic [15:0] pattern, input int len,
                                         input int state, input logic b);
    int   res;
    int   j;
    logic ok;
    logic pb;
    logic sb;
    res = 0;
    if (state > len) begin
      res = 0;
    end else begin
      for (int k = len; k >= 1; k--) begin
        if (res == 0 && k <= state + 1) begin
          ok = 1'b1;
          for (int i = 0; i < k; i++) begin
            pb = pattern[len-1-i];
            j  = state + 1 - k + i;
            sb = (j == state) ? b : pattern[len-1-j];
            if (pb != sb) ok = 1'b0;
            else ok = ok;
          end
          if (ok) res = k;
          else res = res;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// 8-bit saturating event counter used to tally entries into the MATCH state.
module seq_match_counter
  import seq_detect_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Saturating increment, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (inc && (count_r != 8'd255)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial sequence detector with overlap support (KMP transition table built at elaboration).
// Defining SEQDET_MATCH_COUNT_EN adds the saturating match_count output.
module seq_detect_moore
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
`ifdef SEQDET_MATCH_COUNT_EN
  output logic             detect,
  output logic [CNT_W-1:0] match_count
`else
  output logic             detect
`endif
);

  localparam int            SW          = $clog2(PAT_LEN + 1);
  localparam int            NS          = 2 ** SW;
  localparam logic [15:0]   PAT_EXT     = 16'(PATTERN);
  localparam logic [SW-1:0] MATCH_STATE = SW'(PAT_LEN);

  logic [SW-1:0] state_r;
  logic [SW-1:0] state_next_s;
  logic          detect_r;
  logic [SW-1:0] nxt0_s [NS];
  logic [SW-1:0] nxt1_s [NS];

  // Unused encodings beyond MATCH fall back to S0
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    localparam int N0 = calc_next_state(PAT_EXT, PAT_LEN, k, 1'b0);
    localparam int N1 = calc_next_state(PAT_EXT, PAT_LEN, k, 1'b1);
    assign nxt0_s[k] = SW'(N0);
    assign nxt1_s[k] = SW'(N1);
  end

  // Next-state selection from the constant transition table
  always_comb begin
    state_next_s = state_r;
    if (in) begin
      state_next_s = nxt1_s[state_r];
    end else begin
      state_next_s = nxt0_s[state_r];
    end
  end

  // State register and registered MATCH decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= '0;
      detect_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      detect_r <= (state_next_s == MATCH_STATE);
    end
  end

  assign detect = detect_r;

`ifdef SEQDET_MATCH_COUNT_EN
  logic enter_match_s;
  assign enter_match_s = (state_next_s == MATCH_STATE);

  seq_match_counter u_match_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (enter_match_s),
    .count (match_count)
  );
`endif

endmodule

// File: tb/tb_seq_detect_moore.sv
// Scoreboard bench for seq_detect_moore: stimulus pushes expectations from a bit-history model,
// a monitor pops and compares one entry per clock.
module tb_seq_detect_moore;

  localparam int          PAT_LEN = 4;
  localparam logic [15:0] PAT_VEC = 16'h000B;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in = 1'b0;
  logic detect;
`ifdef SEQDET_MATCH_COUNT_EN
  logic [7:0] match_count;
`endif

  seq_detect_moore #(.PAT_LEN(PAT_LEN), .PATTERN(4'b1011)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
`ifdef SEQDET_MATCH_COUNT_EN
    .detect      (detect),
    .match_count (match_count)
`else
    .detect      (detect)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic det;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  bit   hist[$];
  int   mcount = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;
  logic [15:0] pat_v = PAT_VEC;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, expv);
    end
  endtask

  // Reference model: a match is "the last PAT_LEN bits since reset equal the pattern"
  task automatic drive(input logic b, input logic r);
    exp_t e;
    bit   m;
    @(negedge clk);
    in    = b;
    reset = r;
    if (r) begin
      hist.delete();
      mcount = 0;
      e.det  = 1'b0;
    end else begin
      hist.push_back(b);
      if (hist.size() > PAT_LEN) void'(hist.pop_front());
      m = (hist.size() == PAT_LEN);
      for (int i = 0; i < PAT_LEN; i++)
        if (m && hist[i] != pat_v[PAT_LEN-1-i]) m = 1'b0;
      if (m && mcount < 255) mcount++;
      e.det = m;
    end
    e.cnt = mcount;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input int n, input logic [63:0] v);
    for (int i = n - 1; i >= 0; i--) drive(v[i], 1'b0);
  endtask

  // Monitor: one DUT response per clock, compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cycle++;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("detect", int'(detect), int'(e.det));
`ifdef SEQDET_MATCH_COUNT_EN
        check("match_count", int'(match_count), e.cnt);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle zero
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    // Single match within a longer stream
    send_bits(10, 64'b1011001010);
    // Overlapping matches
    drive(1'b0, 1'b1);
    send_bits(7, 64'b1011011);
    // Near miss then recovery
    drive(1'b0, 1'b1);
    send_bits(6, 64'b101011);
    // Reset mid-match, with in=1 on the reset edge, then a 1
    drive(1'b0, 1'b1);
    send_bits(3, 64'b101);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    // Randomized stream with occasional pattern injection and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) drive(1'(($urandom_range(0, 1))), 1'b1);
      else if ($urandom_range(0, 9) == 0) send_bits(4, 64'hB);
      else drive(1'($urandom_range(0, 1)), 1'b0);
    end
`ifdef SEQDET_MATCH_COUNT_EN
    // Counter climb past 70 and saturation at 255
    drive(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) send_bits(4, 64'hB);
`endif
    drive(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
